// File: rtl/alu_result_display_pkg.sv
// Shared definitions for the ALU result display block.
//   - calculator FSM state codes seen on the ALU result bus
//   - active-low 7-segment patterns (gfedcba order) and the digit decoder
//   - state type of the sequential binary-to-BCD engine
package alu_result_display_pkg;

    localparam logic [5:0] ST_START = 6'd0;
    localparam logic [5:0] ST_ADD   = 6'd9;
    localparam logic [5:0] ST_SUB   = 6'd10;
    localparam logic [5:0] ST_SUM   = 6'd11;
    localparam logic [5:0] ST_MUL   = 6'd12;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    // Decimal digit to active-low gfedcba; anything above 9 is blanked.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// ALU result bus as seen by the display reader.
//   state   calculator FSM state
//   neg     subtraction result is negative
//   sum_add / sum_sub / sum_mul / sum_neg  ALU results (WIDTH bits)
// Signalling: this is a level bus with no valid/ready pair. The ALU keeps
// every field stable while it holds a state; the reader samples fields on the
// first clock edge of SUM and ignores them at all other times.
interface alu_result_display_if #(
    parameter int WIDTH = 13
);
    logic [5:0]       state;
    logic             neg;
    logic [WIDTH-1:0] sum_add;
    logic [WIDTH-1:0] sum_sub;
    logic [WIDTH-1:0] sum_mul;
    logic [WIDTH-1:0] sum_neg;

    modport master (output state, neg, sum_add, sum_sub, sum_mul, sum_neg);
    modport slave  (input  state, neg, sum_add, sum_sub, sum_mul, sum_neg);
endinterface

// File: rtl/alu_result_display_bin2bcd_seq.sv
// Sequential shift/add-3 (double dabble) binary to 4-digit BCD converter.
//   clk, clr_n  clock, asynchronous active-low reset
//   start       load bin and begin converting (ignored while busy)
//   abort       drop any conversion and clear bcd/done
//   bin         binary input, WIDTH bits
//   busy        conversion in progress (SHIFT state)
//   done        one-cycle pulse after bcd was updated
//   last        final shift cycle; the result is written on this edge
//   bcd         converted result, [15:12] = thousands
//   fsm_state   current engine state
module bin2bcd_seq
    import alu_result_display_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             last,
    output logic [15:0]      bcd,
    output conv_state_t      fsm_state
);

    localparam int CW = $clog2(WIDTH);

    conv_state_t      cur, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work_bin;
    logic [15:0]      work_bcd;
    logic [15:0]      adj;
    logic [15:0]      shifted;

    // Add 3 to every nibble >= 5 so the following shift carries into the
    // next decimal digit instead of producing a nibble above 9.
    always_comb begin
        adj = work_bcd;
        for (int i = 0; i < 4; i++) begin
            if (work_bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted   = {adj[14:0], work_bin[WIDTH-1]};
    assign last      = (cur == CONV_SHIFT) && (cnt == CW'(WIDTH - 1));
    assign busy      = (cur == CONV_SHIFT);
    assign fsm_state = cur;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cur <= CONV_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            CONV_IDLE:  if (start && !abort) nxt = CONV_SHIFT;
            CONV_SHIFT: if (abort || last)   nxt = CONV_IDLE;
            default:    nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt      <= '0;
            work_bin <= '0;
            work_bcd <= '0;
            bcd      <= '0;
            done     <= 1'b0;
        end else if (abort) begin
            cnt  <= '0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cur == CONV_IDLE) begin
                if (start) begin
                    work_bin <= bin;
                    work_bcd <= '0;
                    cnt      <= '0;
                end
            end else begin
                work_bcd <= shifted;
                work_bin <= {work_bin[WIDTH-2:0], 1'b0};
                cnt      <= cnt + 1'b1;
                if (last) begin
                    bcd  <= shifted;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// Reader side of the ALU result bus: remembers the last arithmetic op,
// converts the result to BCD on entry to SUM and drives a 5-digit
// multiplexed active-low 7-segment display (sign + 4 magnitude digits).
//   clk, clr_n  clock, asynchronous active-low reset
//   bus         ALU result bus (slave side)
//   busy        conversion in progress
//   done        one-cycle pulse: bcd/sign_o updated
//   bcd         displayed magnitude, 4 BCD digits, [15:12] = thousands
//   sign_o      displayed value is negative
//   an          digit enables, active-low, an[4] = sign digit
//   seg         segments gfedcba, active-low
//   dbg_state   state of the BCD conversion engine
module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int WIDTH    = 13,
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 clr_n,
    alu_result_display_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          bcd,
    output logic                 sign_o,
    output logic [4:0]           an,
    output logic [6:0]           seg,
    output conv_state_t          dbg_state
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [5:0]       last_op;
    logic [5:0]       prev_state;
    logic [WIDTH-1:0] operand;
    logic             sign_pend;
    logic             start_r;
    logic             trigger;
    logic             abort;
    logic             conv_busy;
    logic             conv_last;
    logic [DW-1:0]    div_cnt;
    logic [2:0]       idx;

    assign abort   = (bus.state == ST_START);
    assign trigger = (bus.state == ST_SUM) && (prev_state != ST_SUM) && !busy;
    // start_r covers the cycle between capture and the engine entering SHIFT.
    assign busy    = start_r | conv_busy;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_op    <= ST_ADD;
            prev_state <= ST_START;
            operand    <= '0;
            sign_pend  <= 1'b0;
            start_r    <= 1'b0;
            sign_o     <= 1'b0;
        end else begin
            prev_state <= bus.state;
            if (bus.state == ST_ADD || bus.state == ST_SUB || bus.state == ST_MUL) begin
                last_op <= bus.state;
            end
            start_r <= trigger && !abort;
            if (trigger) begin
                if (last_op == ST_SUB) begin
                    operand <= bus.neg ? bus.sum_neg : bus.sum_sub;
                end else if (last_op == ST_MUL) begin
                    operand <= bus.sum_mul;
                end else begin
                    operand <= bus.sum_add;
                end
                sign_pend <= (last_op == ST_SUB) && bus.neg;
            end
            // Sign moves to the display on the same edge as the digits.
            if (abort) begin
                sign_o <= 1'b0;
            end else if (conv_last) begin
                sign_o <= sign_pend;
            end
        end
    end

    bin2bcd_seq #(
        .WIDTH (WIDTH)
    ) u_conv (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start_r),
        .abort     (abort),
        .bin       (operand),
        .busy      (conv_busy),
        .done      (done),
        .last      (conv_last),
        .bcd       (bcd),
        .fsm_state (dbg_state)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else if (div_cnt == DW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        an = 5'b11111;
        case (idx)
            3'd0:    an = 5'b11110;
            3'd1:    an = 5'b11101;
            3'd2:    an = 5'b11011;
            3'd3:    an = 5'b10111;
            3'd4:    an = 5'b01111;
            default: an = 5'b11111;
        endcase
    end

    // A magnitude digit is blanked when it and every higher digit are zero;
    // the ones digit is always lit so zero shows as "0".
    always_comb begin
        seg = SEG_BLANK;
        case (idx)
            3'd0: seg = seg_digit(bcd[3:0]);
            3'd1: seg = (bcd[15:4]  == 12'd0) ? SEG_BLANK : seg_digit(bcd[7:4]);
            3'd2: seg = (bcd[15:8]  == 8'd0)  ? SEG_BLANK : seg_digit(bcd[11:8]);
            3'd3: seg = (bcd[15:12] == 4'd0)  ? SEG_BLANK : seg_digit(bcd[15:12]);
            3'd4: seg = sign_o ? SEG_MINUS : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;
    import alu_result_display_pkg::*;

    localparam int W  = 13;
    localparam int SD = 4;
    localparam logic [5:0] ST_IDLE = 6'd1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_display_if #(.WIDTH(W)) bus ();

    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        sign_o;
    logic [4:0]  an;
    logic [6:0]  seg;
    conv_state_t dbg_state;

    alu_result_display #(
        .WIDTH    (W),
        .SCAN_DIV (SD)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .sign_o    (sign_o),
        .an        (an),
        .seg       (seg),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          fails  = 0;
    logic [16:0] exp_q[$];
    logic [5:0]  model_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'h40; 1: s = 7'h79; 2: s = 7'h24; 3: s = 7'h30; 4: s = 7'h19;
            5: s = 7'h12; 6: s = 7'h02; 7: s = 7'h78; 8: s = 7'h00; 9: s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        chk("reset_an", 32'(an), 32'h1E);
        chk("reset_seg", 32'(seg), 32'h40);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_bcd", 32'(bcd), 0);
        chk("reset_sign", 32'(sign_o), 0);
        model_op = ST_ADD;
        exp_q.delete();
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    task automatic check_scan();
        int idx;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            idx = ((k + 1) / SD) % 5;
            chk("scan_an", 32'(an), 32'(5'h1F ^ (5'd1 << idx)));
        end
    endtask

    task automatic check_display(input int mag, input bit sgn);
        int idx;
        int pw;
        logic [4:0] seen;
        logic [6:0] exp_seg;
        seen = '0;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            case (an)
                5'b11110: idx = 0;
                5'b11101: idx = 1;
                5'b11011: idx = 2;
                5'b10111: idx = 3;
                5'b01111: idx = 4;
                default:  idx = -1;
            endcase
            if (idx < 0) begin
                chk("an_onehot", 32'(an), 32'h1E);
            end else begin
                seen[idx] = 1'b1;
                if (idx == 4) begin
                    exp_seg = sgn ? 7'h3F : 7'h7F;
                end else begin
                    pw = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
                    exp_seg = (idx > 0 && mag < pw) ? 7'h7F : seg_ref((mag / pw) % 10);
                end
                chk($sformatf("seg_digit%0d", idx), 32'(seg), 32'(exp_seg));
            end
        end
        chk("scan_coverage", 32'(seen), 32'h1F);
    endtask

    // Present op with operands a,b, enter SUM, follow the conversion.
    task automatic run_conv(input logic [5:0] op, input int a, input int b,
                            input int retrig_at, input int abort_at);
        int mag;
        bit sgn;
        int n;
        int dones;
        int first_done;
        logic [15:0] bcd_before;
        logic [16:0] exp;

        @(posedge clk);
        #1;
        bus.sum_add = W'((a + b) % 8192);
        bus.sum_mul = W'((a * b) % 8192);
        bus.sum_sub = W'((a - b) & 8191);
        bus.sum_neg = W'((b - a) & 8191);
        bus.neg     = (a < b);
        bus.state   = op;
        if (op == ST_ADD || op == ST_SUB || op == ST_MUL) model_op = op;

        if (model_op == ST_SUB) begin
            mag = (a >= b) ? a - b : b - a;
            sgn = (a < b);
        end else if (model_op == ST_MUL) begin
            mag = (a * b) % 8192;
            sgn = 1'b0;
        end else begin
            mag = (a + b) % 8192;
            sgn = 1'b0;
        end

        @(posedge clk);
        #1 bus.state = ST_SUM;
        bcd_before = bcd;
        @(posedge clk);
        #1;
        chk("busy_after_capture", 32'(busy), 1);
        if (abort_at < 0) exp_q.push_back({sgn, to_bcd(mag)});

        n = 0;
        dones = 0;
        first_done = 0;
        while (n < 20) begin
            if (n == retrig_at)     bus.state = ST_IDLE;
            if (n == retrig_at + 1) bus.state = ST_SUM;
            if (n == abort_at)      bus.state = ST_START;
            if (n == abort_at + 1)  bus.state = ST_IDLE;
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                dones++;
                if (first_done == 0) first_done = n;
            end
            if (n == 13 && abort_at < 0) chk("bcd_hold", 32'(bcd), 32'(bcd_before));
        end

        if (abort_at < 0) begin
            exp = exp_q.pop_front();
            chk("done_latency", 32'(first_done), 14);
            chk("done_count", 32'(dones), 1);
            chk("bcd", 32'(bcd), 32'(exp[15:0]));
            chk("sign_o", 32'(sign_o), 32'(exp[16]));
            chk("busy_end", 32'(busy), 0);
            check_display(mag, sgn);
        end else begin
            chk("abort_no_done", 32'(dones), 0);
            chk("abort_bcd", 32'(bcd), 0);
            chk("abort_sign", 32'(sign_o), 0);
            chk("abort_busy", 32'(busy), 0);
            check_display(0, 1'b0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [5:0] rop;
        int ra;
        int rb;

        bus.state   = ST_IDLE;
        bus.neg     = 1'b0;
        bus.sum_add = '0;
        bus.sum_sub = '0;
        bus.sum_mul = '0;
        bus.sum_neg = '0;
        model_op    = ST_ADD;

        do_reset();
        check_scan();

        run_conv(ST_IDLE, 77, 0, -1, -1);      // no op seen since reset: ADD
        run_conv(ST_ADD, 1234, 0, -1, -1);
        run_conv(ST_SUB, 0, 4, -1, -1);
        run_conv(ST_MUL, 8191, 1, 5, -1);      // SUM re-entry while busy
        run_conv(ST_ADD, 5555, 0, -1, 6);      // abort mid-conversion
        run_conv(ST_ADD, 0, 0, -1, -1);
        run_conv(ST_ADD, 1000, 0, -1, -1);
        run_conv(ST_SUB, 0, 4096, -1, -1);
        run_conv(ST_SUB, 4096, 96, -1, -1);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       rop = ST_ADD;
                1:       rop = ST_SUB;
                default: rop = ST_MUL;
            endcase
            ra = int'($urandom_range(0, 8191));
            rb = int'($urandom_range(0, 8191));
            run_conv(rop, ra, rb, -1, -1);
        end

        repeat (6) @(posedge clk);
        do_reset();
        check_scan();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
